// File: rtl/lcd_timing_param_ctrl_if.sv
// lcd_timing_param_ctrl_if: pixel FIFO read port between the frame-buffer FIFO and the LCD timing controller
//   oREAD_EN    : read request from the controller (master) to the FIFO
//   iREAD_DATA  : 32-bit pixel word presented by the FIFO
//   iDATA_VALID : the FIFO has a word on iREAD_DATA
interface lcd_timing_param_ctrl_if;
    logic        oREAD_EN;
    logic [31:0] iREAD_DATA;
    logic        iDATA_VALID;
    modport master (output oREAD_EN, input iREAD_DATA, input iDATA_VALID);
    modport slave  (input oREAD_EN, output iREAD_DATA, output iDATA_VALID);
endinterface

// File: rtl/lcd_timing_param_ctrl.sv
// lcd_timing_param_ctrl: raster timing generator and RGB888/RGB565 pixel formatter for an LCD panel fed from a pixel FIFO
//   iCLK, iRST_n     : pixel clock, asynchronous active-low reset
//   iEN              : run enable; low parks the raster at (0,0) with idle outputs
//   iPIX_MODE        : 0 = RGB888 in [31:8], 1 = two RGB565 pixels per word (frame-synchronous)
//   iCLR_UNDERFLOW   : clears the sticky underflow flag
//   fifo             : FIFO read port (read request, pixel word, word valid)
//   oHD, oVD, oDEN   : registered hsync, vsync, data enable
//   oLCD_R/G/B       : registered pixel colour
//   oFRAME_START     : one-cycle pulse aligned with the first output cycle of a frame
//   oUNDERFLOW       : sticky flag, set when a pixel is consumed with no valid word
module lcd_timing_param_ctrl #(
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 215,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 34,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PREFETCH = 1
) (
    input  logic                    iCLK,
    input  logic                    iRST_n,
    input  logic                    iEN,
    input  logic                    iPIX_MODE,
    input  logic                    iCLR_UNDERFLOW,
    lcd_timing_param_ctrl_if.master fifo,
    output logic                    oHD,
    output logic                    oVD,
    output logic                    oDEN,
    output logic [7:0]              oLCD_R,
    output logic [7:0]              oLCD_G,
    output logic [7:0]              oLCD_B,
    output logic                    oFRAME_START,
    output logic                    oUNDERFLOW
);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] H_START    = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_STOP     = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_LAST     = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] V_START    = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_STOP     = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  V_LAST     = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [11:0] PF         = 12'(PREFETCH);
    localparam logic        HS_ON      = 1'(HS_POL);
    localparam logic        VS_ON      = 1'(VS_POL);
    // Pixel-index parity from the raw counter: p = x - H_START, and the pixel
    // requested at x is x + PREFETCH - H_START.
    localparam logic        START_ODD  = 1'((H_SYNC + H_BP) % 2);
    localparam logic        READ_ODD   = 1'((H_SYNC + H_BP + PREFETCH) % 2);

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        mode_q, mode_d;
    logic [15:0] lat_q, lat_d;
    logic        hd_q, hd_d, vd_q, vd_d, den_q, den_d, fs_q, fs_d, uf_q, uf_d;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] xe, rx;
    logic [10:0] ye;
    logic        x_end, y_end, v_act, act, odd, consume, valid, rd_en;
    logic [31:0] word;
    logic [23:0] pix;

    function automatic logic [23:0] rgb565(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    always_comb begin
        xe      = {1'b0, x_q};
        ye      = {1'b0, y_q};
        rx      = xe + PF;
        valid   = fifo.iDATA_VALID;
        word    = fifo.iREAD_DATA;
        x_end   = x_q == H_LAST;
        y_end   = y_q == V_LAST;
        x_d     = (!iEN || x_end) ? '0 : x_q + 11'd1;
        y_d     = !iEN ? '0 : x_end ? (y_end ? '0 : y_q + 10'd1) : y_q;
        // Mode only changes between frames, or freely while stopped.
        mode_d  = (!iEN || (x_end && y_end)) ? iPIX_MODE : mode_q;
        v_act   = iEN && ye >= V_START && ye < V_STOP;
        act     = v_act && xe >= H_START && xe < H_STOP;
        odd     = mode_q && (x_q[0] ^ START_ODD);
        consume = act && !odd;
        // An invalid even word latches zero, so its odd partner is black too.
        lat_d   = !iEN ? '0 : (consume && mode_q) ? (valid ? word[15:0] : '0) : lat_q;
        pix     = !mode_q ? (valid ? word[31:8] : '0) :
                  odd     ? rgb565(lat_q) :
                  (valid  ? rgb565(word[31:16]) : '0);
        uf_d    = (consume && !valid) ? 1'b1 : iCLR_UNDERFLOW ? 1'b0 : uf_q;
        rd_en   = v_act && rx >= H_START && rx < H_STOP && !(mode_q && (x_q[0] ^ READ_ODD));
        hd_d    = (iEN && xe < H_SYNC_END) ? HS_ON : !HS_ON;
        vd_d    = (iEN && ye < V_SYNC_END) ? VS_ON : !VS_ON;
        den_d   = act;
        rgb_d   = act ? pix : '0;
        fs_d    = iEN && x_q == '0 && y_q == '0;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= 1'b0;
            lat_q  <= '0;
            hd_q   <= !HS_ON;
            vd_q   <= !VS_ON;
            den_q  <= 1'b0;
            rgb_q  <= '0;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
            lat_q  <= lat_d;
            hd_q   <= hd_d;
            vd_q   <= vd_d;
            den_q  <= den_d;
            rgb_q  <= rgb_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
        end
    end

    assign fifo.oREAD_EN = rd_en;
    assign oHD           = hd_q;
    assign oVD           = vd_q;
    assign oDEN          = den_q;
    assign oLCD_R        = rgb_q[23:16];
    assign oLCD_G        = rgb_q[15:8];
    assign oLCD_B        = rgb_q[7:0];
    assign oFRAME_START  = fs_q;
    assign oUNDERFLOW    = uf_q;
endmodule

// File: tb/tb_lcd_timing_param_ctrl.sv
// tb_lcd_timing_param_ctrl: directed bench for the LCD timing controller on a 14x7 raster
module tb_lcd_timing_param_ctrl;
    logic       iCLK = 1'b0;
    logic       iRST_n, iEN, iPIX_MODE, iCLR_UNDERFLOW;
    logic       oHD, oVD, oDEN, oFRAME_START, oUNDERFLOW;
    logic [7:0] oLCD_R, oLCD_G, oLCD_B;
    int         passed = 0;
    int         total = 0;
    logic       ufm;

    lcd_timing_param_ctrl_if fifo();

    lcd_timing_param_ctrl #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .HS_POL(0), .VS_POL(0), .PREFETCH(2)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iEN(iEN), .iPIX_MODE(iPIX_MODE),
        .iCLR_UNDERFLOW(iCLR_UNDERFLOW), .fifo(fifo),
        .oHD(oHD), .oVD(oVD), .oDEN(oDEN),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
        .oFRAME_START(oFRAME_START), .oUNDERFLOW(oUNDERFLOW)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s idx=%0d got=%h expected=%h", tag, idx, obs, exp_v);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hd"}, 0, oHD, 1);
        chk({tag, "_vd"}, 0, oVD, 1);
        chk({tag, "_den"}, 0, oDEN, 0);
        chk({tag, "_rgb"}, 0, {oLCD_R, oLCD_G, oLCD_B}, 0);
        chk({tag, "_fs"}, 0, oFRAME_START, 0);
        chk({tag, "_rd"}, 0, fifo.oREAD_EN, 0);
        chk({tag, "_uf"}, 0, oUNDERFLOW, 0);
    endtask

    // One 98-cycle frame starting with the counter at (0,0). Outputs seen after
    // tick k decode raster index k-1; oREAD_EN decodes index k mod 98.
    task automatic run_frame(input logic m, input logic [23:0] ev, input logic [23:0] od,
                             input int bad, input int clr, input int sw);
        int i, j, x, y, xr, yr;
        logic act, odd, rd;
        logic [23:0] rgb;
        for (int k = 1; k <= 98; k++) begin
            i = k - 1;
            fifo.iDATA_VALID = i != bad;
            iCLR_UNDERFLOW = i == clr;
            if (i == sw) iPIX_MODE = 1'b1;
            tick();
            x = i % 14;
            y = i / 14;
            act = x >= 4 && x < 12 && y >= 2 && y < 6;
            odd = m && (x % 2 == 1);
            rgb = (!act || i == bad || (odd && i - 1 == bad)) ? 24'h0 : odd ? od : ev;
            if (act && !odd && i == bad) ufm = 1'b1;
            else if (i == clr) ufm = 1'b0;
            j = k % 98;
            xr = j % 14;
            yr = j / 14;
            rd = yr >= 2 && yr < 6 && xr >= 2 && xr < 10 && (!m || xr % 2 == 0);
            chk("hd", i, oHD, x >= 2);
            chk("vd", i, oVD, y >= 1);
            chk("den", i, oDEN, act);
            chk("rgb", i, {oLCD_R, oLCD_G, oLCD_B}, rgb);
            chk("fs", i, oFRAME_START, i == 0);
            chk("uf", i, oUNDERFLOW, ufm);
            chk("rd", j, fifo.oREAD_EN, rd);
        end
        fifo.iDATA_VALID = 1'b1;
        iCLR_UNDERFLOW = 1'b0;
    endtask

    initial begin
        iRST_n = 1'b0;
        iEN = 1'b1;
        iPIX_MODE = 1'b0;
        iCLR_UNDERFLOW = 1'b0;
        fifo.iREAD_DATA = 32'h12345678;
        fifo.iDATA_VALID = 1'b1;
        ufm = 1'b0;
        tick();
        tick();
        check_reset("reset");
        iRST_n = 1'b1;
        run_frame(1'b0, 24'h123456, 24'h0, -1, -1, -1);
        run_frame(1'b0, 24'h123456, 24'h0, 35, -1, 40);
        fifo.iREAD_DATA = 32'hF80007E0;
        run_frame(1'b1, 24'hFF0000, 24'h00FF00, 48, -1, -1);
        run_frame(1'b1, 24'hFF0000, 24'h00FF00, 50, 50, -1);
        run_frame(1'b1, 24'hFF0000, 24'h00FF00, -1, 10, -1);
        repeat (47) tick();
        iEN = 1'b0;
        iPIX_MODE = 1'b0;
        tick();
        chk("rd_after_drop", 47, fifo.oREAD_EN, 0);
        tick();
        chk("idle_hd", 0, oHD, 1);
        chk("idle_vd", 0, oVD, 1);
        chk("idle_den", 0, oDEN, 0);
        chk("idle_rgb", 0, {oLCD_R, oLCD_G, oLCD_B}, 0);
        chk("idle_fs", 0, oFRAME_START, 0);
        tick();
        chk("idle_fs2", 0, oFRAME_START, 0);
        chk("idle_rd2", 0, fifo.oREAD_EN, 0);
        iEN = 1'b1;
        fifo.iREAD_DATA = 32'h12345678;
        run_frame(1'b0, 24'h123456, 24'h0, -1, -1, -1);
        for (int j = 0; j < 36; j++) begin
            fifo.iDATA_VALID = j != 33;
            tick();
        end
        fifo.iDATA_VALID = 1'b1;
        chk("pre_rst_uf", 35, oUNDERFLOW, 1);
        chk("pre_rst_den", 35, oDEN, 1);
        chk("pre_rst_rgb", 35, {oLCD_R, oLCD_G, oLCD_B}, 32'h123456);
        iRST_n = 1'b0;
        #1;
        check_reset("async_rst");
        tick();
        iRST_n = 1'b1;
        ufm = 1'b0;
        run_frame(1'b0, 24'h123456, 24'h0, -1, -1, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
